// File: rtl/piano_octave_renderer_if.sv
// Signal bundle shared by the PS/2 byte receiver, the VGA timing core and the piano renderer.
// The master side is the source of scan bytes and pixel coordinates; the slave side is the renderer.
interface piano_octave_renderer_if #(
  parameter int NUM_OCTAVES = 2
);
  logic                      iScanValid;
  logic [7:0]                iScanCode;
  logic [9:0]                iCol;
  logic [9:0]                iRow;
  logic                      iActive;
  logic                      oR;
  logic                      oG;
  logic                      oB;
  logic [12*NUM_OCTAVES-1:0] oKeyMask;
  logic [2:0]                oOctave;

  modport master (
    output iScanValid, iScanCode, iCol, iRow, iActive,
    input  oR, oG, oB, oKeyMask, oOctave
  );

  modport slave (
    input  iScanValid, iScanCode, iCol, iRow, iActive,
    output oR, oG, oB, oKeyMask, oOctave
  );
endinterface

// File: rtl/piano_octave_renderer.sv
// PS/2 scan-code decoder tracking held piano keys, plus a 2-stage VGA pixel renderer
// that draws NUM_OCTAVES octaves and highlights held keys in yellow.
module piano_octave_renderer #(
  parameter int NUM_OCTAVES = 2,
  parameter int KEY_W       = 40,
  parameter int BLACK_W     = 24,
  parameter int LINE_W      = 2,
  parameter int X0          = 40,
  parameter int Y_TOP       = 100,
  parameter int Y_SPLIT     = 240,
  parameter int Y_BOT       = 380
) (
  input  logic                  Clock,
  input  logic                  Reset,
  piano_octave_renderer_if.slave bus
);

  localparam int MW = 12 * NUM_OCTAVES;
  localparam int IW = $clog2(MW + 16);
  localparam int PW = 1 << IW;
  localparam int OW = $clog2(KEY_W);

  localparam logic [7:0] NOTE_CODE [12] = '{
    8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A,
    8'h34, 8'h32, 8'h33, 8'h31, 8'h3B, 8'h3A
  };

  localparam logic [2:0] C_BLACK  = 3'b000;
  localparam logic [2:0] C_BLUE   = 3'b001;
  localparam logic [2:0] C_YELLOW = 3'b110;
  localparam logic [2:0] C_WHITE  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BRK,
    S_EXT,
    S_EXT_BRK
  } scan_state_t;

  scan_state_t   state_q;
  logic [MW-1:0] mask_q;
  logic [2:0]    octave_q;
  logic [11:0]   note_hit;
  logic [MW-1:0] key_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 12; gi++) begin : g_note
      assign note_hit[gi] = (bus.iScanCode == NOTE_CODE[gi]);
    end
    // A note byte addresses exactly one bit: its note within the current octave.
    // An out-of-range octave selects nothing.
    for (gi = 0; gi < MW; gi++) begin : g_sel
      assign key_sel[gi] = note_hit[gi % 12] && (octave_q == 3'(gi / 12));
    end
  endgenerate

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      mask_q   <= '0;
      octave_q <= '0;
    end else if (bus.iScanValid) begin
      case (state_q)
        S_IDLE: begin
          if (bus.iScanCode == 8'hF0) begin
            state_q <= S_BRK;
          end else if (bus.iScanCode == 8'hE0) begin
            state_q <= S_EXT;
          end else if (bus.iScanCode == 8'h4E) begin
            if (octave_q != 3'd0) octave_q <= octave_q - 3'd1;
          end else if (bus.iScanCode == 8'h55) begin
            if (octave_q < 3'(NUM_OCTAVES - 1)) octave_q <= octave_q + 3'd1;
          end else begin
            mask_q <= mask_q | key_sel;
          end
        end
        S_BRK: begin
          mask_q  <= mask_q & ~key_sel;
          state_q <= S_IDLE;
        end
        S_EXT: begin
          state_q <= (bus.iScanCode == 8'hF0) ? S_EXT_BRK : S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.oKeyMask = mask_q;
  assign bus.oOctave  = octave_q;

  // Geometry counters hold the position of the next pixel; wm7 is the white key
  // within its octave and oct12 is 12*octave, so no divide or multiply is needed.
  logic          run_q, run_d, cur_run;
  logic [OW-1:0] off_q, off_d, cur_off;
  logic [2:0]    wm7_q, wm7_d, cur_wm7;
  logic [IW-1:0] oct12_q, oct12_d, cur_oct12;

  always_comb begin
    if (bus.iActive && (bus.iCol == 10'(X0))) begin
      cur_run   = 1'b1;
      cur_off   = '0;
      cur_wm7   = '0;
      cur_oct12 = '0;
    end else begin
      cur_run   = run_q;
      cur_off   = off_q;
      cur_wm7   = wm7_q;
      cur_oct12 = oct12_q;
    end

    run_d   = cur_run && bus.iActive;
    off_d   = cur_off;
    wm7_d   = cur_wm7;
    oct12_d = cur_oct12;
    if (cur_run && bus.iActive) begin
      if (cur_off == OW'(KEY_W - 1)) begin
        off_d = '0;
        if (cur_wm7 == 3'd6) begin
          wm7_d   = '0;
          oct12_d = cur_oct12 + IW'(12);
          if (cur_oct12 == IW'(12 * (NUM_OCTAVES - 1))) run_d = 1'b0;
        end else begin
          wm7_d = cur_wm7 + 3'd1;
        end
      end else begin
        off_d = cur_off + OW'(1);
      end
    end
  end

  logic [3:0]    white_note;
  logic          black_r, black_l;
  logic [PW-1:0] mask_pad;
  logic [IW-1:0] idx_w, idx_r, idx_l;
  logic          upper;
  logic [2:0]    pix_d;

  always_comb begin
    white_note = 4'd0;
    case (cur_wm7)
      3'd0:    white_note = 4'd0;
      3'd1:    white_note = 4'd2;
      3'd2:    white_note = 4'd4;
      3'd3:    white_note = 4'd5;
      3'd4:    white_note = 4'd7;
      3'd5:    white_note = 4'd9;
      default: white_note = 4'd11;
    endcase
  end

  // Right-hand black key sits on C,D,F,G,A; the left-hand one belongs to D,E,G,A,B
  // and is always in the same octave because B has no black key to its right.
  assign black_r  = (cur_wm7 == 3'd0) || (cur_wm7 == 3'd1) || (cur_wm7 == 3'd3) ||
                    (cur_wm7 == 3'd4) || (cur_wm7 == 3'd5);
  assign black_l  = (cur_wm7 == 3'd1) || (cur_wm7 == 3'd2) || (cur_wm7 == 3'd4) ||
                    (cur_wm7 == 3'd5) || (cur_wm7 == 3'd6);
  assign mask_pad = PW'(mask_q);
  assign idx_w    = cur_oct12 + IW'(white_note);
  assign idx_r    = idx_w + IW'(1);
  assign idx_l    = idx_w - IW'(1);
  assign upper    = bus.iRow < 10'(Y_SPLIT);

  always_comb begin
    pix_d = C_BLACK;
    if (!bus.iActive) begin
      pix_d = C_BLACK;
    end else if ((bus.iRow < 10'(Y_TOP)) || (bus.iRow >= 10'(Y_BOT)) || !cur_run) begin
      pix_d = C_BLUE;
    end else if (upper && (cur_off >= OW'(KEY_W - BLACK_W / 2)) && black_r) begin
      pix_d = mask_pad[idx_r] ? C_YELLOW : C_BLACK;
    end else if (upper && (cur_off < OW'(BLACK_W / 2)) && black_l) begin
      pix_d = mask_pad[idx_l] ? C_YELLOW : C_BLACK;
    end else if (cur_off < OW'(LINE_W)) begin
      pix_d = C_BLACK;
    end else begin
      pix_d = mask_pad[idx_w] ? C_YELLOW : C_WHITE;
    end
  end

  logic [2:0] col1_q, rgb_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      run_q   <= 1'b0;
      off_q   <= '0;
      wm7_q   <= '0;
      oct12_q <= '0;
      col1_q  <= C_BLACK;
      rgb_q   <= C_BLACK;
    end else begin
      run_q   <= run_d;
      off_q   <= off_d;
      wm7_q   <= wm7_d;
      oct12_q <= oct12_d;
      col1_q  <= pix_d;
      rgb_q   <= col1_q;
    end
  end

  assign bus.oR = rgb_q[2];
  assign bus.oG = rgb_q[1];
  assign bus.oB = rgb_q[0];

endmodule

// File: tb/tb_piano_octave_renderer.sv
// Randomized bench for piano_octave_renderer: scan bytes and full pixel lines are
// compared against a behavioural model computed from column arithmetic.
module tb_piano_octave_renderer;

  localparam int NO      = 2;
  localparam int MW      = 12 * NO;
  localparam int KEY_W   = 40;
  localparam int BLACK_W = 24;
  localparam int LINE_W  = 2;
  localparam int X0      = 40;
  localparam int Y_TOP   = 100;
  localparam int Y_SPLIT = 240;
  localparam int Y_BOT   = 380;

  localparam logic [7:0] NOTE_CODES [12] = '{
    8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A,
    8'h34, 8'h32, 8'h33, 8'h31, 8'h3B, 8'h3A
  };
  localparam int WHITE_NOTE [7] = '{0, 2, 4, 5, 7, 9, 11};
  localparam logic [7:0] RAND_CODES [17] = '{
    8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34, 8'h32, 8'h33,
    8'h31, 8'h3B, 8'h3A, 8'hF0, 8'hF0, 8'hE0, 8'h4E, 8'h55
  };

  logic Clock;
  logic Reset;
  piano_octave_renderer_if #(.NUM_OCTAVES(NO)) bus ();

  piano_octave_renderer #(
    .NUM_OCTAVES(NO), .KEY_W(KEY_W), .BLACK_W(BLACK_W), .LINE_W(LINE_W),
    .X0(X0), .Y_TOP(Y_TOP), .Y_SPLIT(Y_SPLIT), .Y_BOT(Y_BOT)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural model: held notes, octave, and pending prefix bytes
  logic [MW-1:0] held;
  int            octave;
  bit            saw_f0, saw_e0, saw_e0f0;

  function automatic int note_of(input logic [7:0] code);
    for (int i = 0; i < 12; i++) if (NOTE_CODES[i] == code) return i;
    return -1;
  endfunction

  task automatic model_byte(input logic [7:0] code);
    int n;
    n = note_of(code);
    if (saw_e0f0) begin
      saw_e0f0 = 0;
    end else if (saw_e0) begin
      saw_e0   = 0;
      saw_e0f0 = (code == 8'hF0);
    end else if (saw_f0) begin
      saw_f0 = 0;
      if (n >= 0 && octave < NO) held[octave * 12 + n] = 1'b0;
    end else if (code == 8'hF0) begin
      saw_f0 = 1;
    end else if (code == 8'hE0) begin
      saw_e0 = 1;
    end else if (code == 8'h4E) begin
      if (octave > 0) octave--;
    end else if (code == 8'h55) begin
      if (octave < NO - 1) octave++;
    end else if (n >= 0 && octave < NO) begin
      held[octave * 12 + n] = 1'b1;
    end
  endtask

  function automatic bit has_black_right(input int wi);
    return (wi != 2) && (wi != 6);
  endfunction

  function automatic logic [2:0] key_colour(input int bit_idx, input bit is_black);
    if (held[bit_idx]) return 3'b110;
    return is_black ? 3'b000 : 3'b111;
  endfunction

  function automatic logic [2:0] ref_pixel(input int col, input int row, input bit act);
    int x, w, off, wl;
    if (!act) return 3'b000;
    if (row < Y_TOP || row >= Y_BOT || col < X0 || col >= X0 + 7 * NO * KEY_W) return 3'b001;
    x   = col - X0;
    w   = x / KEY_W;
    off = x % KEY_W;
    if (row < Y_SPLIT) begin
      if (off >= KEY_W - BLACK_W / 2 && has_black_right(w % 7))
        return key_colour((w / 7) * 12 + WHITE_NOTE[w % 7] + 1, 1);
      wl = w - 1;
      if (off < BLACK_W / 2 && w > 0 && has_black_right(wl % 7))
        return key_colour((wl / 7) * 12 + WHITE_NOTE[wl % 7] + 1, 1);
    end
    if (off < LINE_W) return 3'b000;
    return key_colour((w / 7) * 12 + WHITE_NOTE[w % 7], 0);
  endfunction

  typedef struct {
    int         col;
    int         row;
    logic [2:0] exp;
  } pix_t;

  pix_t       pq[$];
  logic [2:0] got_line [0:1023];

  // One clock: drive inputs, predict the pixel with the pre-update mask, then
  // check the pixel issued two cycles earlier and any scan-byte effect.
  task automatic step(input int col, input int row, input bit act, input bit sv, input logic [7:0] code);
    pix_t       p;
    logic [2:0] rgb;
    bus.iCol       = 10'(col);
    bus.iRow       = 10'(row);
    bus.iActive    = act;
    bus.iScanValid = sv;
    bus.iScanCode  = code;
    p.col = col;
    p.row = row;
    p.exp = ref_pixel(col, row, act);
    pq.push_back(p);
    if (sv) model_byte(code);
    @(posedge Clock);
    #1;
    bus.iScanValid = 1'b0;
    if (pq.size() == 2) begin
      p   = pq.pop_front();
      rgb = {bus.oR, bus.oG, bus.oB};
      got_line[p.col] = rgb;
      check_value($sformatf("pixel c%0d r%0d", p.col, p.row), 32'(rgb), 32'(p.exp));
    end
    if (sv) begin
      check_value("mask", 32'(bus.oKeyMask), 32'(held));
      check_value("octave", 32'(bus.oOctave), 32'(octave));
      $display("scan byte %h -> mask %h octave %0d", code, bus.oKeyMask, bus.oOctave);
    end
  endtask

  task automatic send(input logic [7:0] code);
    step(0, 0, 1'b0, 1'b1, code);
  endtask

  function automatic logic [7:0] rand_code();
    int r;
    r = $urandom_range(19);
    if (r < 17) return RAND_CODES[r];
    return 8'($urandom);
  endfunction

  task automatic render(input int row, input int rate);
    bit sv;
    for (int c = 0; c < 660; c++) begin
      sv = (rate != 0) && ($urandom_range(rate - 1) == 0);
      step(c, row, c < 640, sv, sv ? rand_code() : 8'h00);
    end
    $display("line row %0d rendered, mask %h octave %0d", row, bus.oKeyMask, bus.oOctave);
  endtask

  initial begin
    held     = '0;
    octave   = 0;
    saw_f0   = 0;
    saw_e0   = 0;
    saw_e0f0 = 0;

    Reset          = 1'b1;
    bus.iScanValid = 1'b0;
    bus.iScanCode  = 8'h00;
    bus.iCol       = '0;
    bus.iRow       = '0;
    bus.iActive    = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check_value("reset_mask", 32'(bus.oKeyMask), 32'd0);
    check_value("reset_octave", 32'(bus.oOctave), 32'd0);
    check_value("reset_rgb", 32'({bus.oR, bus.oG, bus.oB}), 32'd0);
    Reset = 1'b0;

    send(8'h1A);
    check_value("z_make_bit0", 32'(bus.oKeyMask[0]), 32'd1);
    send(8'hF0); send(8'h1A);
    check_value("z_break_mask", 32'(bus.oKeyMask), 32'd0);

    send(8'h1A); send(8'h3B);
    check_value("zj_bits", 32'(bus.oKeyMask), 32'h401);
    send(8'hF0); send(8'h3B);
    check_value("j_release", 32'(bus.oKeyMask), 32'h001);
    send(8'hF0); send(8'h1A);

    send(8'h55); send(8'h55); send(8'h55);
    check_value("octave_sat_hi", 32'(bus.oOctave), 32'd1);
    send(8'h1B);
    check_value("s_oct1_bit13", 32'(bus.oKeyMask), 32'h2000);
    send(8'hF0); send(8'h1B);
    send(8'h4E); send(8'h4E);
    check_value("octave_sat_lo", 32'(bus.oOctave), 32'd0);

    send(8'hE0); send(8'hF0); send(8'h1A);
    check_value("ext_ignored", 32'(bus.oKeyMask), 32'd0);
    send(8'h1A);
    check_value("after_ext_make", 32'(bus.oKeyMask), 32'd1);
    send(8'hF0); send(8'h1A);

    send(8'h1B);
    render(150, 0);
    check_value("csharp_held", 32'(got_line[X0 + KEY_W - 1]), 32'b110);
    check_value("d_white", 32'(got_line[X0 + KEY_W + BLACK_W / 2]), 32'b111);
    render(300, 0);
    check_value("divider", 32'(got_line[X0 + KEY_W]), 32'b000);
    check_value("past_span", 32'(got_line[X0 + 14 * KEY_W]), 32'b001);
    check_value("inactive", 32'(got_line[650]), 32'b000);

    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(8)) send(rand_code());
      render($urandom_range(80, 420), 24);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
